incdev_seq_sched: RTL and testbench

- Program-order scheduler between the reference-CPU side and the user CPU in the incremental-development harness.
- Every retired reference instruction is enqueued as a typed entry in one ordered queue:
  - EXEC: dispatch the instruction to the user CPU.
  - WB: apply a reference register write directly.
  - PCINC: sequential PC step.
  - PCSET: redirect to a branch, exception or special-instruction target.
- The head entry is applied only after every earlier user execution has finished, so architectural-state updates can never overtake in-flight user instructions.
- ref_pause throttles the reference CPU on near-full, and a watchdog flags a hung user CPU.

---
 rtl/incdev_seq_sched.sv | 126 ++++++++++++
 tb/tb_incdev_seq_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/incdev_seq_sched.sv
// incdev_seq_sched: program-order scheduler that applies reference-CPU entries after in-flight user executions finish.
// Define INCDEV_SCHED_BYPASS_EN to apply an entry straight from enq_* when the queue is empty and the FSM is idle.
module incdev_seq_sched #(
    parameter int DEPTH       = 16,
    parameter int PAUSE_SLACK = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [1:0]               enq_kind,
    input  logic [31:0]              enq_pc,
    input  logic [31:0]              enq_data,
    input  logic [4:0]               enq_wreg,
    input  logic                     enq_we,
    output logic                     ref_pause,
    output logic                     usr_ex_flag,
    output logic [31:0]              usr_ex_inst,
    output logic [31:0]              usr_ex_pc,
    input  logic                     usr_ex_finish,
    output logic                     usr_wb_we,
    output logic [31:0]              usr_wb_pc,
    output logic [31:0]              usr_wb_wdata,
    output logic [4:0]               usr_wb_wreg,
    output logic                     usr_pc_inc,
    output logic                     usr_pc_we,
    output logic [31:0]              usr_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     err_timeout,
    output logic                     err_spurious
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   PAUSE_AT = (AW+1)'(DEPTH - PAUSE_SLACK);
    localparam logic [WW-1:0] TO_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;
    typedef enum logic [1:0] {K_EXEC, K_WB, K_PCINC, K_PCSET} kind_t;

    state_t        state, state_nx;
    logic [71:0]   mem [DEPTH];
    logic [71:0]   head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ_nx;
    logic [WW-1:0] wdog;
    logic          push, push_q, pop, bypass, issue, timeout_hit;
    kind_t         head_kind;

    assign enq_ready = occupancy != FULL;
    assign push      = enq_valid & enq_ready;
`ifdef INCDEV_SCHED_BYPASS_EN
    assign bypass    = push & (occupancy == '0) & (state == IDLE);
`else
    assign bypass    = 1'b0;
`endif
    assign push_q    = push & !bypass;
    assign pop       = (state == IDLE) & (occupancy != '0);
    assign issue     = pop | bypass;
    // A bypassed entry never touches the queue, so the head comes from the inputs.
    assign head      = bypass ? {enq_kind, enq_pc, enq_data, enq_wreg, enq_we} : mem[rd_ptr];
    assign head_kind = kind_t'(head[71:70]);
    assign occ_nx    = occupancy + (AW+1)'(push_q) - (AW+1)'(pop);
    assign timeout_hit = (state == WAIT) & !usr_ex_finish & (wdog == TO_LAST);

    always_comb begin
        state_nx = state;
        if (issue && head_kind == K_EXEC)
            state_nx = WAIT;
        else if (state == WAIT && usr_ex_finish)
            state_nx = IDLE;
        else if (timeout_hit)
            state_nx = HALT;
    end

    always_ff @(posedge clk)
        if (push_q) mem[wr_ptr] <= {enq_kind, enq_pc, enq_data, enq_wreg, enq_we};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            wdog         <= '0;
            ref_pause    <= 1'b0;
            usr_ex_flag  <= 1'b0;
            usr_ex_inst  <= '0;
            usr_ex_pc    <= '0;
            usr_wb_we    <= 1'b0;
            usr_wb_pc    <= '0;
            usr_wb_wdata <= '0;
            usr_wb_wreg  <= '0;
            usr_pc_inc   <= 1'b0;
            usr_pc_we    <= 1'b0;
            usr_pc       <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            state        <= state_nx;
            occupancy    <= occ_nx;
            ref_pause    <= occ_nx >= PAUSE_AT;
            wr_ptr       <= push_q ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr       <= pop ? rd_ptr + AW'(1) : rd_ptr;
            wdog         <= (state == WAIT) ? wdog + WW'(1) : '0;
            usr_ex_flag  <= issue && head_kind == K_EXEC;
            usr_wb_we    <= issue && head_kind == K_WB && head[0];
            usr_pc_inc   <= issue && head_kind == K_PCINC;
            usr_pc_we    <= issue && head_kind == K_PCSET;
            if (issue && head_kind == K_EXEC) begin
                usr_ex_inst <= head[37:6];
                usr_ex_pc   <= head[69:38];
            end
            if (issue && head_kind == K_WB) begin
                usr_wb_pc    <= head[69:38];
                usr_wb_wdata <= head[37:6];
                usr_wb_wreg  <= head[5:1];
            end
            if (issue && head_kind == K_PCSET)
                usr_pc <= head[37:6];
            err_timeout  <= err_timeout | timeout_hit;
            err_spurious <= err_spurious | (usr_ex_finish && state != WAIT);
        end
    end
endmodule

// File: tb/tb_incdev_seq_sched.sv
// tb_incdev_seq_sched: directed scenario tests for incdev_seq_sched; builds with or without INCDEV_SCHED_BYPASS_EN.
module tb_incdev_seq_sched;
`ifdef INCDEV_SCHED_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif
    logic        clk = 1'b0, rstn = 1'b0;
    logic        enq_valid = 1'b0, enq_we = 1'b0, usr_ex_finish = 1'b0;
    logic [1:0]  enq_kind = '0;
    logic [31:0] enq_pc = '0, enq_data = '0;
    logic [4:0]  enq_wreg = '0;
    logic        enq_ready, ref_pause, usr_ex_flag, usr_wb_we, usr_pc_inc, usr_pc_we;
    logic        err_timeout, err_spurious;
    logic [31:0] usr_ex_inst, usr_ex_pc, usr_wb_pc, usr_wb_wdata, usr_pc;
    logic [4:0]  usr_wb_wreg;
    logic [4:0]  occupancy;
    int tests = 0, fails = 0;

    incdev_seq_sched #(.DEPTH(16), .PAUSE_SLACK(4), .TIMEOUT(1024)) dut (
        .clk(clk), .rstn(rstn), .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_kind(enq_kind), .enq_pc(enq_pc), .enq_data(enq_data), .enq_wreg(enq_wreg),
        .enq_we(enq_we), .ref_pause(ref_pause), .usr_ex_flag(usr_ex_flag),
        .usr_ex_inst(usr_ex_inst), .usr_ex_pc(usr_ex_pc), .usr_ex_finish(usr_ex_finish),
        .usr_wb_we(usr_wb_we), .usr_wb_pc(usr_wb_pc), .usr_wb_wdata(usr_wb_wdata),
        .usr_wb_wreg(usr_wb_wreg), .usr_pc_inc(usr_pc_inc), .usr_pc_we(usr_pc_we),
        .usr_pc(usr_pc), .occupancy(occupancy), .err_timeout(err_timeout),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [31:0] pc, input logic [31:0] d,
                         input logic [4:0] r, input logic we);
        enq_valid = 1'b1; enq_kind = k; enq_pc = pc; enq_data = d; enq_wreg = r; enq_we = we;
    endtask

    task automatic idle();
        enq_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0; idle(); usr_ex_finish = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [8:0] got;
        #3;
        got = {enq_ready, ref_pause, usr_ex_flag, usr_wb_we, usr_pc_inc, usr_pc_we, err_timeout, err_spurious, occupancy == 5'd0};
        tests++;
        if (got !== 9'b1_0000_0001) begin
            fails++; $display("FAIL reset_outputs got=%b want=%b", got, 9'b1_0000_0001);
        end
        tests++;
        if ({usr_ex_inst, usr_wb_wdata, usr_pc} !== 96'd0) begin
            fails++; $display("FAIL reset_data got=%h want=0", {usr_ex_inst, usr_wb_wdata, usr_pc});
        end
        @(negedge clk) rstn = 1'b1;
        tick();
    endtask

    task automatic test_drain();
        logic [2:0] got, want;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(2'd1, 32'h1C000010, 32'h1234, 5'd4, 1'b1);
            else if (i == 1) drive(2'd2, 32'h1C000014, 32'h0, 5'd0, 1'b0);
            else if (i == 2) drive(2'd3, 32'h1C000018, 32'h1C000100, 5'd0, 1'b0);
            else idle();
            tick();
            got  = {usr_wb_we, usr_pc_inc, usr_pc_we};
            want = {i == LAT, i == LAT + 1, i == LAT + 2};
            tests++;
            if (got !== want) begin
                fails++; $display("FAIL drain_pulses cycle=%0d got=%b want=%b", i, got, want);
            end
        end
        tests++;
        if ({usr_wb_wreg, usr_wb_wdata, usr_wb_pc, usr_pc} !== {5'd4, 32'h1234, 32'h1C000010, 32'h1C000100}) begin
            fails++; $display("FAIL drain_data wreg=%0d wdata=%h wbpc=%h pc=%h want 4 1234 1c000010 1c000100",
                              usr_wb_wreg, usr_wb_wdata, usr_wb_pc, usr_pc);
        end
        tests++;
        if (occupancy !== 5'd0) begin
            fails++; $display("FAIL drain_empty got=%0d want=0", occupancy);
        end
    endtask

    task automatic test_exec_wait();
        int bad = 0;
        drive(2'd0, 32'h1C000000, 32'h02800421, 5'd0, 1'b0);
        tick();
        tests++;
        if (usr_ex_flag !== (LAT == 0)) begin
            fails++; $display("FAIL exec_flag_early got=%b want=%b", usr_ex_flag, LAT == 0);
        end
        drive(2'd1, 32'h1C000004, 32'hABCD, 5'd5, 1'b1);
        tick();
        idle();
        tests++;
        if ({usr_ex_flag, usr_ex_inst, usr_ex_pc} !== {LAT == 1, 32'h02800421, 32'h1C000000}) begin
            fails++; $display("FAIL exec_dispatch flag=%b inst=%h pc=%h want %b 02800421 1c000000",
                              usr_ex_flag, usr_ex_inst, usr_ex_pc, LAT == 1);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (usr_wb_we !== 1'b0 || occupancy !== 5'd1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL exec_hold bad_cycles=%0d want=0", bad);
        end
        usr_ex_finish = 1'b1;
        tick();
        usr_ex_finish = 1'b0;
        tests++;
        if ({usr_wb_we, occupancy} !== {1'b0, 5'd1}) begin
            fails++; $display("FAIL exec_bubble we=%b occ=%0d want 0 1", usr_wb_we, occupancy);
        end
        tick();
        tests++;
        if ({usr_wb_we, usr_wb_wreg, usr_wb_wdata, occupancy, err_spurious} !== {1'b1, 5'd5, 32'hABCD, 5'd0, 1'b0}) begin
            fails++; $display("FAIL exec_release we=%b wreg=%0d wdata=%h occ=%0d spur=%b want 1 5 abcd 0 0",
                              usr_wb_we, usr_wb_wreg, usr_wb_wdata, occupancy, err_spurious);
        end
    endtask

    task automatic test_full_pause();
        logic [6:0] got, want;
        do_reset();
        drive(2'd0, 32'h1C000000, 32'h0, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        for (int n = 1; n <= 16; n++) begin
            drive(2'd2, 32'h0, 32'h0, 5'd0, 1'b0);
            tick();
            got  = {occupancy, ref_pause, enq_ready};
            want = {5'(n), n >= 12, n < 16};
            tests++;
            if (got !== want) begin
                fails++; $display("FAIL fill n=%0d got occ/pause/ready=%b want=%b", n, got, want);
            end
        end
        tick();
        idle();
        tests++;
        if ({occupancy, enq_ready, ref_pause} !== {5'd16, 1'b0, 1'b1}) begin
            fails++; $display("FAIL overflow occ=%0d ready=%b pause=%b want 16 0 1", occupancy, enq_ready, ref_pause);
        end
    endtask

    task automatic test_timeout();
        int n = 0, c = 0, pulses = 0;
        do_reset();
        drive(2'd0, 32'h1C000020, 32'h1111, 5'd0, 1'b0);
        tick();
        idle();
        while (!usr_ex_flag && n < 4) begin
            tick();
            n++;
        end
        tests++;
        if (usr_ex_flag !== 1'b1) begin
            fails++; $display("FAIL timeout_dispatch got=%b want=1", usr_ex_flag);
        end
        drive(2'd2, 32'h0, 32'h0, 5'd0, 1'b0);
        do begin
            tick();
            idle();
            c++;
            pulses += int'(usr_ex_flag | usr_wb_we | usr_pc_inc | usr_pc_we);
        end while (!err_timeout && c < 1100);
        tests++;
        if (c != 1024 || err_timeout !== 1'b1) begin
            fails++; $display("FAIL timeout_cycles got=%0d err=%b want=1024 1", c, err_timeout);
        end
        repeat (10) begin
            tick();
            pulses += int'(usr_ex_flag | usr_wb_we | usr_pc_inc | usr_pc_we);
        end
        tests++;
        if (pulses != 0 || occupancy !== 5'd1 || err_spurious !== 1'b0) begin
            fails++; $display("FAIL halt_quiet pulses=%0d occ=%0d spur=%b want 0 1 0", pulses, occupancy, err_spurious);
        end
        usr_ex_finish = 1'b1;
        tick();
        usr_ex_finish = 1'b0;
        tests++;
        if ({err_spurious, err_timeout} !== 2'b11) begin
            fails++; $display("FAIL halt_spurious got=%b want=11", {err_spurious, err_timeout});
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive(2'd0, 32'h1C000040, 32'h2222, 5'd0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(2'd2, 32'h0, 32'h0, 5'd0, 1'b0);
            tick();
        end
        idle();
        tests++;
        if (occupancy !== 5'd5) begin
            fails++; $display("FAIL wait_queued got=%0d want=5", occupancy);
        end
        #2 rstn = 1'b0;
        #1;
        tests++;
        if ({occupancy, enq_ready, ref_pause, usr_ex_flag, usr_wb_we, usr_pc_inc, usr_pc_we} !== {5'd0, 6'b100000}) begin
            fails++; $display("FAIL async_reset occ=%0d ready=%b pause=%b pulses=%b want 0 1 0 0000",
                              occupancy, enq_ready, ref_pause, {usr_ex_flag, usr_wb_we, usr_pc_inc, usr_pc_we});
        end
        @(negedge clk) rstn = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        drive(2'd2, 32'h1C000050, 32'h0, 5'd0, 1'b0);
        tick();
        idle();
        tests++;
        if ({usr_pc_inc, occupancy} !== {LAT == 0, 5'(LAT)}) begin
            fails++; $display("FAIL pcinc_edge_k inc=%b occ=%0d want %b %0d", usr_pc_inc, occupancy, LAT == 0, LAT);
        end
        tick();
        tests++;
        if ({usr_pc_inc, occupancy} !== {LAT == 1, 5'd0}) begin
            fails++; $display("FAIL pcinc_edge_k1 inc=%b occ=%0d want %b 0", usr_pc_inc, occupancy, LAT == 1);
        end
        usr_ex_finish = 1'b1;
        tick();
        usr_ex_finish = 1'b0;
        tests++;
        if (err_spurious !== 1'b1) begin
            fails++; $display("FAIL post_reset_spurious got=%b want=1", err_spurious);
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_exec_wait();
        test_full_pause();
        test_timeout();
        test_reset_mid_wait();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
